// File: rtl/axi4s_packet_receiver.sv
// AXI4-Stream sink: FWFT beat FIFO plus per-packet summary (len/id/dest/user/err), 1-cycle latency.
// TREADY falls when the FIFO holds DEPTH beats and rises the cycle after a pop; no input-to-ready path.
module axi4s_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          wr;
  logic          rd;

  assign full   = (cnt == (AW+1)'(DEPTH));
  assign rd_vld = (cnt != '0);
  assign wr     = wr_vld && !full;
  assign rd     = rd_rdy && rd_vld;
  // Head is forced to zero when empty so stale storage never shows after reset.
  assign rd_dat = rd_vld ? mem[rp] : '0;

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      if (wr && !rd)      cnt <= cnt + (AW+1)'(1);
      else if (rd && !wr) cnt <= cnt - (AW+1)'(1);
    end
  end
endmodule

module axi4s_packet_receiver #(
  parameter int N     = 1,
  parameter int I     = 1,
  parameter int D     = 1,
  parameter int U     = 1,
  parameter int DEPTH = 8,
  parameter int LEN_W = 16
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             TVALID,
  output logic             TREADY,
  input  logic [8*N-1:0]   TDATA,
  input  logic [N-1:0]     TSTRB,
  input  logic [N-1:0]     TKEEP,
  input  logic             TLAST,
  input  logic [I-1:0]     TID,
  input  logic [D-1:0]     TDEST,
  input  logic [U-1:0]     TUSER,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [8*N-1:0]   rd_data,
  output logic [N-1:0]     rd_strb,
  output logic [N-1:0]     rd_keep,
  output logic             rd_last,
  output logic             pkt_done,
  output logic [LEN_W-1:0] pkt_len,
  output logic [I-1:0]     pkt_id,
  output logic [D-1:0]     pkt_dest,
  output logic [U-1:0]     pkt_user,
  output logic [1:0]       pkt_err
);
  localparam int W = 8*N + 2*N + 1;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t           state;
  logic             ready_en;
  logic             full;
  logic             push;
  logic [W-1:0]     head;
  logic [LEN_W-1:0] acc;
  logic [I-1:0]     cap_id;
  logic [D-1:0]     cap_dest;
  logic             err_mm;
  logic             err_sat;

  logic [LEN_W:0]   pc;
  logic [LEN_W:0]   sum;
  logic [LEN_W-1:0] new_len;
  logic             new_mm;
  logic             new_sat;
  logic             in_pkt;

  // ready_en keeps TREADY low while reset is held and for no longer.
  assign TREADY = ready_en && !full;
  assign push   = TVALID && TREADY && ((TKEEP != '0) || TLAST);
  assign in_pkt = (state == IN_PKT);

  axi4s_rx_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk    (ACLK),
    .rst_n  (ARESETn),
    .wr_vld (push),
    .wr_dat ({TDATA, TSTRB, TKEEP, TLAST}),
    .rd_rdy (rd_en),
    .rd_vld (rd_valid),
    .rd_dat (head),
    .full   (full)
  );

  assign {rd_data, rd_strb, rd_keep, rd_last} = head;

  always_comb begin
    pc = '0;
    for (int b = 0; b < N; b++) pc = pc + (LEN_W+1)'(TKEEP[b]);
    sum     = (in_pkt ? {1'b0, acc} : '0) + pc;
    new_len = sum[LEN_W] ? '1 : sum[LEN_W-1:0];
    new_sat = (in_pkt && err_sat) || sum[LEN_W];
    new_mm  = in_pkt && (err_mm || (TID != cap_id) || (TDEST != cap_dest));
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state    <= IDLE;
      ready_en <= 1'b0;
      acc      <= '0;
      cap_id   <= '0;
      cap_dest <= '0;
      err_mm   <= 1'b0;
      err_sat  <= 1'b0;
      pkt_done <= 1'b0;
      pkt_len  <= '0;
      pkt_id   <= '0;
      pkt_dest <= '0;
      pkt_user <= '0;
      pkt_err  <= '0;
    end else begin
      ready_en <= 1'b1;
      pkt_done <= 1'b0;
      if (push) begin
        if (TLAST) begin
          state    <= IDLE;
          pkt_done <= 1'b1;
          pkt_len  <= new_len;
          pkt_id   <= in_pkt ? cap_id : TID;
          pkt_dest <= in_pkt ? cap_dest : TDEST;
          pkt_user <= TUSER;
          pkt_err  <= {new_sat, new_mm};
        end else begin
          state   <= IN_PKT;
          acc     <= new_len;
          err_mm  <= new_mm;
          err_sat <= new_sat;
          if (!in_pkt) begin
            cap_id   <= TID;
            cap_dest <= TDEST;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_axi4s_packet_receiver.sv
// Randomized and directed bench for axi4s_packet_receiver against a queue-based packet model.
module tb_axi4s_packet_receiver;
  localparam int N = 4, I = 2, D = 2, U = 2, DEPTH = 8, LEN_W = 4;
  localparam int MAXL = (1 << LEN_W) - 1;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        TVALID = 1'b0;
  logic        TREADY;
  logic [31:0] TDATA = '0;
  logic [3:0]  TSTRB = '0;
  logic [3:0]  TKEEP = '0;
  logic        TLAST = 1'b0;
  logic [1:0]  TID = '0, TDEST = '0, TUSER = '0;
  logic        rd_en = 1'b0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [3:0]  rd_strb, rd_keep;
  logic        rd_last;
  logic        pkt_done;
  logic [3:0]  pkt_len;
  logic [1:0]  pkt_id, pkt_dest, pkt_user, pkt_err;

  axi4s_packet_receiver #(.N(N), .I(I), .D(D), .U(U), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .TVALID(TVALID), .TREADY(TREADY), .TDATA(TDATA),
    .TSTRB(TSTRB), .TKEEP(TKEEP), .TLAST(TLAST), .TID(TID), .TDEST(TDEST), .TUSER(TUSER),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data), .rd_strb(rd_strb),
    .rd_keep(rd_keep), .rd_last(rd_last), .pkt_done(pkt_done), .pkt_len(pkt_len),
    .pkt_id(pkt_id), .pkt_dest(pkt_dest), .pkt_user(pkt_user), .pkt_err(pkt_err)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic [3:0]  keep;
    logic        last;
  } fbeat_t;

  typedef struct packed {
    logic [3:0] keep;
    logic [1:0] id;
    logic [1:0] dest;
    logic [1:0] user;
  } pbeat_t;

  fbeat_t     q[$];
  pbeat_t     pb[$];
  logic       e_rdy_en = 1'b0;
  logic       e_done = 1'b0;
  logic [3:0] e_len = '0;
  logic [1:0] e_id = '0, e_dest = '0, e_user = '0, e_err = '0;
  logic       armed = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Packet summary straight from the list of stored beats of one packet.
  task automatic summarize();
    int   total = 0;
    logic mm = 1'b0;
    foreach (pb[j]) begin
      total += $countones(pb[j].keep);
      if (pb[j].id != pb[0].id || pb[j].dest != pb[0].dest) mm = 1'b1;
    end
    e_len  = (total > MAXL) ? 4'(MAXL) : 4'(total);
    e_err  = {total > MAXL, mm};
    e_id   = pb[0].id;
    e_dest = pb[0].dest;
    e_user = pb[pb.size()-1].user;
  endtask

  // One clock: check outputs left by the previous edge, drive inputs, advance the model.
  task automatic cyc(input logic rstn, input logic v, input logic [31:0] d, input logic [3:0] k,
                     input logic l, input logic [1:0] id, input logic [1:0] dst,
                     input logic [1:0] usr, input logic re);
    logic   rdy;
    fbeat_t fb;
    pbeat_t pbt;
    rdy = e_rdy_en && (q.size() < DEPTH);
    if (armed) begin
      chk("tready", TREADY, rdy);
      chk("rd_valid", rd_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("rd_data", rd_data, q[0].data);
        chk("rd_strb", rd_strb, q[0].strb);
        chk("rd_keep", rd_keep, q[0].keep);
        chk("rd_last", rd_last, q[0].last);
      end
      if (!e_rdy_en) chk("rst_rd_bus", {rd_data, rd_strb, rd_keep, rd_last}, '0);
      chk("pkt_done", pkt_done, e_done);
      chk("pkt_len", pkt_len, e_len);
      chk("pkt_id", pkt_id, e_id);
      chk("pkt_dest", pkt_dest, e_dest);
      chk("pkt_user", pkt_user, e_user);
      chk("pkt_err", pkt_err, e_err);
    end
    ARESETn = rstn; TVALID = v; TDATA = d; TSTRB = d[7:4]; TKEEP = k; TLAST = l;
    TID = id; TDEST = dst; TUSER = usr; rd_en = re;
    if (!rstn) begin
      q.delete(); pb.delete();
      e_rdy_en = 1'b0; e_done = 1'b0; e_len = '0;
      e_id = '0; e_dest = '0; e_user = '0; e_err = '0;
    end else begin
      e_done = 1'b0;
      if (re && q.size() != 0) q.delete(0);
      if (v && rdy && (k != 0 || l)) begin
        fb.data = d; fb.strb = d[7:4]; fb.keep = k; fb.last = l;
        q.push_back(fb);
        pbt.keep = k; pbt.id = id; pbt.dest = dst; pbt.user = usr;
        pb.push_back(pbt);
        if (l) begin
          summarize();
          pb.delete();
          e_done = 1'b1;
        end
      end
      e_rdy_en = 1'b1;
    end
    armed = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic idle(input logic re);
    cyc(1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 2'd0, 2'd0, 2'd0, re);
  endtask

  task automatic bt(input logic [3:0] k, input logic l, input logic [1:0] id,
                    input logic [1:0] dst, input logic [1:0] usr, input logic re);
    cyc(1'b1, 1'b1, $urandom, k, l, id, dst, usr, re);
  endtask

  initial begin
    @(negedge ACLK);
    repeat (3) cyc(1'b0, 1'b1, $urandom, 4'hF, 1'b1, 2'd1, 2'd1, 2'd1, 1'b1);
    idle(1'b0);
    chk("tp_ready_after_rst", TREADY, 1'b1);

    bt(4'hF, 1'b0, 2'd2, 2'd1, 2'd0, 1'b0);
    bt(4'hF, 1'b0, 2'd2, 2'd1, 2'd0, 1'b0);
    bt(4'h3, 1'b1, 2'd2, 2'd1, 2'd3, 1'b0);
    chk("tp_3beat_done", pkt_done, 1'b1);
    chk("tp_3beat_len", pkt_len, 4'd10);
    chk("tp_3beat_idd", {pkt_id, pkt_dest, pkt_err}, 6'b10_01_00);
    repeat (4) idle(1'b1);

    repeat (10) bt(4'hF, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    chk("tp_full_ready", TREADY, 1'b0);
    bt(4'hF, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1);
    chk("tp_ready_after_pop", TREADY, 1'b1);
    bt(4'h1, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0);
    repeat (10) idle(1'b1);

    bt(4'hF, 1'b0, 2'd1, 2'd0, 2'd0, 1'b1);
    bt(4'hF, 1'b1, 2'd3, 2'd0, 2'd2, 1'b1);
    chk("tp_mm_err", {pkt_id, pkt_err}, 4'b01_01);

    bt(4'hF, 1'b0, 2'd0, 2'd2, 2'd0, 1'b1);
    bt(4'h0, 1'b0, 2'd0, 2'd2, 2'd0, 1'b1);
    bt(4'h3, 1'b1, 2'd0, 2'd2, 2'd1, 1'b1);
    chk("tp_null_len", pkt_len, 4'd6);
    bt(4'h0, 1'b1, 2'd2, 2'd2, 2'd2, 1'b0);
    chk("tp_null_last", {pkt_done, pkt_len, rd_last}, 6'b1_0000_1);
    repeat (4) idle(1'b1);

    repeat (4) bt(4'hF, 1'b0, 2'd1, 2'd1, 2'd0, 1'b1);
    bt(4'hF, 1'b1, 2'd1, 2'd1, 2'd3, 1'b1);
    chk("tp_sat", {pkt_len, pkt_err}, 6'b1111_10);

    bt(4'hF, 1'b0, 2'd2, 2'd3, 2'd0, 1'b1);
    bt(4'hF, 1'b0, 2'd2, 2'd3, 2'd0, 1'b1);
    cyc(1'b0, 1'b1, $urandom, 4'hF, 1'b1, 2'd2, 2'd3, 2'd0, 1'b0);
    idle(1'b0);
    chk("tp_rst_no_done", pkt_done, 1'b0);
    bt(4'h3, 1'b1, 2'd3, 2'd2, 2'd1, 1'b1);
    chk("tp_len_after_rst", pkt_len, 4'd2);

    for (int c = 0; c < 1500; c++) begin
      logic       v, l, re, rs;
      logic [3:0] k;
      logic [1:0] id, dst;
      v  = $urandom_range(0, 3) != 0;
      k  = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      l  = $urandom_range(0, 3) == 0;
      id = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'd1;
      dst = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'd2;
      re = (c % 300 < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rs = $urandom_range(0, 249) != 0;
      cyc(rs, v, $urandom, k, l, id, dst, 2'($urandom), re);
    end
    repeat (12) idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi4s_packet_receiver.md
# axi4s_packet_receiver

Synthesizable AXI4-Stream receiver, the RTL slave counterpart to the team's AXI4-Stream master BFM. It accepts transfers on an AXI4-Stream slave port and buffers beats in an internal FIFO drained by a simple read port. It also produces a per-packet summary: byte count, TID, TDEST and TUSER, plus error flags. It sits at the input of DUT datapaths and serves as a checkable sink in BFM-driven benches.

## Interface
Parameters:
- N, 1: TDATA width in bytes.
- I, 1: TID width.
- D, 1: TDEST width.
- U, 1: TUSER width.
- DEPTH, 8: FIFO depth in beats. Power of 2, ≥2.
- LEN_W, 16: width of the packet byte counter.

Ports:
- ACLK  in  1: clock. All logic is on the rising edge.
- ARESETn  in  1: reset. Synchronous, active-low.
- TVALID  in  1: stream valid.
- TREADY  out  1: stream ready.
- TDATA  in  8N: data.
- TSTRB  in  N: byte strobes. Stored, not interpreted.
- TKEEP  in  N: byte keep.
- TLAST  in  1: packet end.
- TID  in  I: stream ID.
- TDEST  in  D: destination.
- TUSER  in  U: user sideband.
- rd_en  in  1: pop the FIFO head. Ignored when rd_valid=0.
- rd_valid  out  1: FIFO head valid.
- rd_data  out  8N: head TDATA.
- rd_strb  out  N: head TSTRB.
- rd_keep  out  N: head TKEEP.
- rd_last  out  1: head TLAST.
- pkt_done  out  1: one-cycle pulse when a packet summary is valid.
- pkt_len  out  LEN_W: byte count of the completed packet.
- pkt_id  out  I: TID of the packet's first beat.
- pkt_dest  out  D: TDEST of the packet's first beat.
- pkt_user  out  U: TUSER of the packet's last beat.
- pkt_err  out  2: bit0 = TID/TDEST changed mid-packet; bit1 = length saturated.

## Operation
- A handshake occurs when TVALID and TREADY are both 1 at a rising edge of ACLK.
- TREADY = (occupancy < DEPTH). It depends only on registered state.
  - A pop in the same cycle does not raise TREADY; there is no full-bypass path.
- Each handshaked beat is written to the FIFO, except null beats (TKEEP==0 and TLAST==0).
  - Null beats are discarded entirely and do not affect packet state.
  - A null beat with TLAST=1 is stored and closes the packet.
- Beat byte count = popcount(TKEEP).
- Packet FSM, two states:
  - IDLE → IN_PKT on a handshaked non-null beat with TLAST=0. On this transition, capture TID/TDEST, load acc = popcount, and clear both error bits.
  - IDLE with a handshaked beat and TLAST=1: single-beat packet. Stay in IDLE and complete the packet this beat.
  - IN_PKT: on each handshaked beat, acc += popcount, saturating at 2^LEN_W−1 and setting the sat flag when saturation occurs. Set the mismatch flag if TID or TDEST differs from the captured values.
  - IN_PKT → IDLE on a handshaked beat with TLAST=1.
- Completion: on the cycle after a TLAST handshake:
  - pkt_done=1.
  - pkt_len = final acc, including the last beat.
  - pkt_id/pkt_dest = captured values, or the beat's own values for a single-beat packet.
  - pkt_user = last beat's TUSER.
  - pkt_err = flags, including any mismatch or saturation on the last beat.
  - pkt_len/id/dest/user/err hold until the next completion.
- FIFO is first-word fall-through. rd_valid = (occupancy ≠ 0). rd_* show the head entry. A pop occurs on rd_en && rd_valid.
- Simultaneous push and pop: occupancy is unchanged. Pointers wrap modulo DEPTH.
- Reset (ARESETn=0 at an edge), including mid-packet:
  - TREADY=0, rd_valid=0, pkt_done=0.
  - pkt_len=0, pkt_id=0, pkt_dest=0, pkt_user=0, pkt_err=0.
  - rd_data/strb/keep/last=0; occupancy=0; FSM to IDLE; acc=0; flags cleared.
  - A partial packet is discarded and produces no pkt_done.
  - First cycle after reset release: TREADY=1.

## Timing
- Beat handshaked at edge k: rd_valid=1 and head visible after edge k, provided the FIFO was empty (1-cycle latency).
- TLAST handshaked at edge k: pkt_done high for exactly the cycle after edge k.
- Back-to-back packets are sustained at one beat per cycle. pkt_done may pulse on consecutive cycles for consecutive single-beat packets.
- The FIFO full→not-full transition raises TREADY one cycle after the pop edge.
- No combinational path from TVALID, rd_en or any other input to TREADY or rd_valid.

## Test plan
- Reset then idle → all outputs 0 during reset. TREADY=1 on the first cycle after release.
- N=4, a 3-beat packet with TKEEP=F,F,3, TID=2, TDEST=1, TLAST on beat 3 → pkt_done one cycle after beat 3, pkt_len=10, pkt_id=2, pkt_dest=1, pkt_err=0. rd_* returns 3 beats in order, with rd_last on the third.
- DEPTH=8, rd_en=0, 10 beats offered → exactly 8 accepted; TREADY=0 from the cycle after the 8th. Pulse rd_en once → TREADY=1 one cycle later; beat 9 is accepted.
- Packet with TID=1 on beat 1 and TID=3 on beat 2 → pkt_err=01, pkt_id=1.
- Null beat (TKEEP=0, TLAST=0) mid-packet → not in FIFO, pkt_len excludes it. Null beat with TLAST=1 → stored with rd_last=1, pkt_done fires.
- LEN_W=4, N=4, five beats with TKEEP=F → pkt_len=15, pkt_err=10. Assert ARESETn mid-packet → no pkt_done; the next packet's length starts from 0.
